// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared DFF bank.
// One WRITE cycle (active-low load strobe), HOLD_CYCLES of tenure, then one IDLE cycle.
module dff_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [N_REQ-1:0]       req_in,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       gnt_out,
  output logic                   reg_enable_out,
  output logic [WIDTH-1:0]       reg_data_out,
  output logic                   busy_out
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_last, w_last_nxt;
  logic [IDX_W-1:0]   r_cur, w_cur_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic               r_en_n, w_en_n_nxt;
  logic [WIDTH-1:0]   r_data, w_data_nxt;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;

  // Search starts just after the previous winner and wraps, so the first hit is the fairest.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_last) + 1 + k) % N_REQ;
      if (!w_found && req_in[idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_en_n_nxt  = 1'b1;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_WRITE;
          w_cur_nxt   = w_win;
          w_gnt_nxt   = N_REQ'(1) << w_win;
          w_data_nxt  = data_in[w_win*WIDTH +: WIDTH];
          w_en_n_nxt  = 1'b0;
        end
      end
      ST_WRITE: begin
        if (HOLD_CYCLES == 0) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_cur;
        end else begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES);
        end
      end
      ST_HOLD: begin
        // Tenure ends when the count expires or the owner lets go early.
        if (!req_in[r_cur] || r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
          w_last_nxt  = r_cur;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
      r_last  <= IDX_W'(N_REQ - 1);
      r_cur   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_en_n  <= 1'b1;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_en_n  <= w_en_n_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign gnt_out        = r_gnt;
  assign reg_enable_out = r_en_n;
  assign reg_data_out   = r_data;
  assign busy_out       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Bench for dff_rr_arbiter: tenure-based reference model checked every cycle,
// plus directed scenarios with hand-derived expectations (HOLD_CYCLES=2 and 0).
module tb_dff_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req, req0;
  logic [31:0] data, data0;
  logic [3:0]  gnt, gnt0;
  logic        en_n, en_n0;
  logic [7:0]  q, q0;
  logic        busy, busy0;

  dff_rr_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(2)) dut (
    .clk_in(clk), .reset_in(rst_n), .req_in(req), .data_in(data),
    .gnt_out(gnt), .reg_enable_out(en_n), .reg_data_out(q), .busy_out(busy));

  dff_rr_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(0)) dut0 (
    .clk_in(clk), .reset_in(rst_n), .req_in(req0), .data_in(data0),
    .gnt_out(gnt0), .reg_enable_out(en_n0), .reg_data_out(q0), .busy_out(busy0));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: owner = requester holding the grant (-1 none), age = cycles since its grant edge.
  typedef struct {
    int         owner;
    int         age;
    int         last;
    logic [7:0] data;
  } mst_t;

  function automatic mst_t step(mst_t s, logic rst, logic [3:0] r, logic [31:0] d, int h);
    mst_t n = s;
    if (!rst) begin
      n.owner = -1; n.age = 0; n.last = N - 1; n.data = '0;
    end else if (s.owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (s.last + k) % N;
        if (n.owner < 0 && r[i]) begin
          n.owner = i; n.age = 0; n.data = d[i*W +: W];
        end
      end
    end else if (s.age == 0 && h > 0) begin
      n.age = 1;
    end else if (s.age == 0 || !r[s.owner] || s.age == h) begin
      n.last = s.owner; n.owner = -1; n.age = 0;
    end else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_gnt(mst_t s);
    return (s.owner < 0) ? 32'd0 : (32'd1 << s.owner);
  endfunction

  function automatic logic [31:0] exp_en(mst_t s);
    return (s.owner >= 0 && s.age == 0) ? 32'd0 : 32'd1;
  endfunction

  function automatic logic [31:0] exp_busy(mst_t s);
    return (s.owner >= 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic int oh_idx(logic [3:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  mst_t m  = '{-1, 0, N - 1, 8'h00};
  mst_t m0 = '{-1, 0, N - 1, 8'h00};

  always @(posedge clk) begin
    m  = step(m,  rst_n, req,  data,  2);
    m0 = step(m0, rst_n, req0, data0, 0);
    cyc++;
  end

  int log_idx[$], log_cyc[$], log0_idx[$], log0_cyc[$];
  logic [3:0] gprev = '0, gprev0 = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",     32'(gnt),   exp_gnt(m));
      check("en_n",    32'(en_n),  exp_en(m));
      check("data",    32'(q),     32'(m.data));
      check("busy",    32'(busy),  exp_busy(m));
      check("onehot",  32'($countones(gnt) <= 1), 32'd1);
      check("gnt0",    32'(gnt0),  exp_gnt(m0));
      check("en_n0",   32'(en_n0), exp_en(m0));
      check("data0",   32'(q0),    32'(m0.data));
      check("busy0",   32'(busy0), exp_busy(m0));
      if (gnt != 0 && gprev == 0) begin log_idx.push_back(oh_idx(gnt)); log_cyc.push_back(cyc); end
      if (gnt0 != 0 && gprev0 == 0) begin log0_idx.push_back(oh_idx(gnt0)); log0_cyc.push_back(cyc); end
      gprev  = gnt;
      gprev0 = gnt0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; req = '0; req0 = '0; data = '0; data0 = '0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_en",   32'(en_n), 32'd1);
    check("rst_data", 32'(q),    32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request from 0 with A5; two HOLD cycles then IDLE.
    rst_n = 1'b1; req = 4'b0001; data = {8'h44, 8'h33, 8'h22, 8'hA5};
    tick();
    check("a_gnt",  32'(gnt),  32'h1);
    check("a_en",   32'(en_n), 32'd0);
    check("a_data", 32'(q),    32'hA5);
    tick();
    check("a_hold1", 32'({busy, en_n, gnt}), 32'h31);
    tick();
    check("a_hold2", 32'({busy, en_n, gnt}), 32'h31);
    tick();
    check("a_idle",  32'({busy, gnt}), 32'h0);
    req = '0;

    // All four requesting after reset: order 0,1,2,3 every 4 cycles.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    base = log_idx.size();
    req = 4'b1111; data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    repeat (16) tick();
    req = '0;
    check("b_count", 32'(log_idx.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < log_idx.size()) begin
        check("b_order", 32'(log_idx[base+k]), 32'(k));
        if (k > 0) check("b_spacing", 32'(log_cyc[base+k] - log_cyc[base+k-1]), 32'd4);
      end
    end

    // Requester 2 served (drops req during WRITE, releases early), then 0101 wraps to 0.
    req = 4'b0100;
    tick();
    check("c_gnt2", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("c_hold", 32'({busy, en_n, gnt}), 32'h34);
    tick();
    check("c_rel",  32'({busy, gnt}), 32'h0);
    req = 4'b0101; data = {8'h00, 8'h22, 8'h00, 8'h11};
    tick();
    check("c_wrap_gnt",  32'(gnt), 32'h1);
    check("c_wrap_data", 32'(q),   32'h11);
    tick();
    check("c_hold1", 32'({busy, gnt}), 32'h11);
    req = '0;
    tick();
    check("c_early", 32'({busy, gnt}), 32'h0);

    // Reset during WRITE aborts; requester 0 then has priority, 1 is still served.
    req = 4'b0010;
    tick();
    check("d_gnt1", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    tick();
    check("d_rst", 32'({busy, en_n, q, gnt}), 32'h1000);
    rst_n = 1'b1; req = 4'b0011; data = {8'h00, 8'h00, 8'h77, 8'h66};
    tick();
    check("d_prio0", 32'(gnt), 32'h1);
    check("d_data",  32'(q),   32'h66);
    repeat (7) tick();
    req = '0;

    // HOLD_CYCLES=0 instance: WRITE straight to IDLE, regrant 2 cycles later.
    base = log0_idx.size();
    req0 = 4'b0010; data0 = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    check("e_gnt",  32'({en_n0, gnt0}), 32'h02);
    check("e_data", 32'(q0), 32'h5A);
    tick();
    check("e_idle", 32'({busy0, en_n0, gnt0}), 32'h10);
    tick();
    check("e_regnt", 32'(gnt0), 32'h2);
    req0 = '0;
    tick(); tick();
    check("e_count", 32'(log0_idx.size() - base), 32'd2);
    if (log0_idx.size() - base >= 2)
      check("e_spacing", 32'(log0_cyc[base+1] - log0_cyc[base]), 32'd2);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dff_rr_arbiter.md
DFF_RR_ARBITER -- requirements
Module: dff_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing the register.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the shared register data width.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 2, giving the post-write tenure in cycles (legal range 0..15).
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  synchronous, active-low reset, sampled on rising clk_in.
REQ-006 req_in  input  N_REQ  per-requester write request, level-held until granted.
REQ-007 data_in  input  N_REQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 gnt_out  output  N_REQ  one-hot grant, registered.
REQ-009 reg_enable_out  output  1  active-low load enable to the shared DFF bank; 0 = load reg_data_out on the next edge.
REQ-010 reg_data_out  output  WIDTH  data presented to the shared DFF bank, registered.
REQ-011 busy_out  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, WRITE and HOLD.
REQ-013 In IDLE with any req_in bit high, the block SHALL select a winner round-robin, searching from index (last_winner+1) mod N_REQ upward with wrap-around.
REQ-014 On that edge the block SHALL enter WRITE, set gnt_out to the winner's one-hot value, latch the winner's data_in slice into reg_data_out, and drive reg_enable_out=0.
REQ-015 Latency from a req_in rise in IDLE to gnt_out/reg_enable_out=0 SHALL be exactly 1 cycle.
REQ-016 WRITE SHALL last exactly 1 cycle; reg_enable_out SHALL be 0 only in WRITE and 1 in all other states.
REQ-017 From WRITE the FSM SHALL enter HOLD with hold counter = HOLD_CYCLES, or go to IDLE directly when HOLD_CYCLES = 0.
REQ-018 In HOLD, gnt_out SHALL stay asserted, reg_data_out SHALL stay stable, and the counter SHALL decrement by 1 per cycle; the FSM SHALL enter IDLE on the cycle the counter reaches 1.
REQ-019 If the granted requester's req_in drops during HOLD, the FSM SHALL go to IDLE on the next edge (early release).
REQ-020 On leaving WRITE/HOLD to IDLE, gnt_out SHALL clear, and last_winner SHALL update to the granted index.
REQ-021 The FSM SHALL spend at least 1 cycle in IDLE between grants, so back-to-back grants are spaced by HOLD_CYCLES+2 cycles.
REQ-022 A req_in drop during WRITE SHALL NOT abort the write.
REQ-023 Requests arriving outside IDLE SHALL be ignored until IDLE; no request SHALL be lost while held.
REQ-024 gnt_out SHALL never have more than one bit set.
REQ-025 Under continuous requests from all requesters, each requester SHALL be granted once every N_REQ grants.

Reset
REQ-026 When reset_in=0 at a rising edge, the block SHALL enter IDLE with gnt_out=0, reg_enable_out=1, reg_data_out=0, busy_out=0, hold counter=0 and last_winner=N_REQ-1, so that index 0 has first priority.
REQ-027 Reset asserted mid-WRITE or mid-HOLD SHALL abort the operation on that edge, with no further reg_enable_out=0 pulse.

Verification
REQ-028 Reset release, then req_in=4'b0001 with slice0=8'hA5 -> the next cycle shows gnt_out=0001, reg_enable_out=0, reg_data_out=A5; then 2 HOLD cycles, then IDLE.
REQ-029 req_in=4'b1111 held for 4 grants -> grant order 0,1,2,3, with gnt_out rising edges spaced 4 cycles apart.
REQ-030 After requester 2 is served, req_in=4'b0101 -> requester 0 is granted (wrap-around).
REQ-031 The granted requester drops req_in in the first HOLD cycle -> IDLE on the next edge; busy_out falls.
REQ-032 reset_in=0 during WRITE -> on that edge gnt_out=0, reg_enable_out=1 and reg_data_out=00; after reset, requester 0 has priority.
REQ-033 HOLD_CYCLES=0 with req_in=4'b0010 -> WRITE is followed directly by IDLE, and the next grant follows 2 cycles after the previous one.
